// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wake on req/busy/force_on, close after IDLE_CYCLES idle edges, count gated-off cycles.
// Latency: enable 1 edge after activity, ready WAKE_CYCLES edges later; req is held off (ready=0) until the gated clock runs.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 busy,
    input  logic                 force_on,
    input  logic                 clr_count,
    output logic                 enable,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] gated_count
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idle_cnt_q;
    logic [WW-1:0]          wake_cnt_q;
    logic                   enable_q;
    logic                   ready_q;
    logic [CNT_WIDTH-1:0]   gated_count_q;
    logic [CNT_WIDTH-1:0]   gated_count_d;
    logic                   act;

    assign act = req | busy | force_on;

    // enable/ready are registered decodes of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            enable_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (act) begin
                        state_q    <= ST_WAKE;
                        wake_cnt_q <= WAKE_LOAD;
                        enable_q   <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q != '0) begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end else begin
                        state_q    <= ST_ON;
                        idle_cnt_q <= IDLE_LOAD;
                        ready_q    <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (act) begin
                        idle_cnt_q <= IDLE_LOAD;
                    end else if (idle_cnt_q != '0) begin
                        idle_cnt_q <= idle_cnt_q - 1'b1;
                    end else begin
                        state_q  <= ST_OFF;
                        enable_q <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_OFF;
                    enable_q <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Counts edges whose preceding cycle had the gate closed; clear wins over increment
    always_comb begin
        gated_count_d = gated_count_q;
        if (clr_count) begin
            gated_count_d = '0;
        end else if (!enable_q && (gated_count_q != '1)) begin
            gated_count_d = gated_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_count_q <= '0;
        end else begin
            gated_count_q <= gated_count_d;
        end
    end

    assign enable      = enable_q;
    assign ready       = ready_q;
    assign gated_count = gated_count_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: two parameterisations share stimulus and are compared each cycle
// against a timestamp-based model of the wake/idle rules.
module tb_clk_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, req, busy, force_on, clr_count;
    logic        en0, rdy0, en1, rdy1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(1), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .force_on(force_on),
        .clr_count(clr_count), .enable(en0), .ready(rdy0), .gated_count(cnt0)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(5), .WAKE_CYCLES(3), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .force_on(force_on),
        .clr_count(clr_count), .enable(en1), .ready(rdy1), .gated_count(cnt1)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=off 1=wake 2=on; times are absolute edge numbers
    int     p_wake[2] = '{1, 3};
    int     p_idle[2] = '{8, 5};
    longint p_max[2]  = '{64'hFFFF_FFFF, 15};
    int     m_mode[2];
    longint m_wake_end[2];
    longint m_last_act[2];
    longint m_cnt[2];
    bit     m_xfer[2];
    longint edge_n = 0;

    task automatic chk(input string nm, input longint act_v, input longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_cnt[k]  = 0;
            m_xfer[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit a, was_en;
        if (!rst_n) return;
        a = req | busy | force_on;
        for (int k = 0; k < 2; k++) begin
            was_en    = (m_mode[k] != 0);
            m_xfer[k] = req && (m_mode[k] == 2);
            case (m_mode[k])
                0: if (a) begin
                       m_mode[k]     = 1;
                       m_wake_end[k] = edge_n + p_wake[k];
                   end
                1: if (edge_n == m_wake_end[k]) begin
                       m_mode[k]     = 2;
                       m_last_act[k] = edge_n;
                   end
                default: begin
                    if (a) m_last_act[k] = edge_n;
                    else if (edge_n - m_last_act[k] >= p_idle[k]) m_mode[k] = 0;
                end
            endcase
            if (clr_count) m_cnt[k] = 0;
            else if (!was_en && m_cnt[k] < p_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        edge_n++;
    endtask

    task automatic compare_all();
        chk("enable0", en0,  m_mode[0] != 0);
        chk("ready0",  rdy0, m_mode[0] == 2);
        chk("count0",  cnt0, m_cnt[0]);
        chk("enable1", en1,  m_mode[1] != 0);
        chk("ready1",  rdy1, m_mode[1] == 2);
        chk("count1",  cnt1, m_cnt[1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit d0, d1;
        rst_n = 1'b0; req = 1'b0; busy = 1'b0; force_on = 1'b0; clr_count = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("rst_enable", en0, 0);
        chk("rst_ready",  rdy0, 0);
        chk("rst_count",  cnt0, 0);
        rst_n = 1'b1;

        repeat (20) cyc();
        chk("idle20_count0", cnt0, 20);
        chk("idle20_count_sat", cnt1, 15);
        chk("idle20_enable", en0, 0);

        // wake latency and close latency
        req = 1'b1;
        cyc();
        chk("wake_en_e0", en0, 1);
        chk("wake_rdy_e0", rdy0, 0);
        cyc();
        chk("wake_rdy_e1", rdy0, 1);
        cyc();
        req = 1'b0;
        repeat (7) cyc();
        chk("close_en_7", en0, 1);
        cyc();
        chk("close_en_8", en0, 0);
        chk("close_rdy_8", rdy0, 0);

        // activity exactly when idle counter reaches zero
        req = 1'b1;
        repeat (3) cyc();
        req = 1'b0;
        repeat (7) cyc();
        chk("reload_pre_en", en0, 1);
        req = 1'b1;
        cyc();
        chk("reload_en", en0, 1);
        chk("reload_rdy", rdy0, 1);
        req = 1'b0;
        repeat (8) cyc();
        chk("reload_close", en0, 0);

        // busy alone
        busy = 1'b1;
        repeat (50) cyc();
        chk("busy_en", en0, 1);
        busy = 1'b0;
        repeat (7) cyc();
        chk("busy_close_7", en0, 1);
        cyc();
        chk("busy_close_8", en0, 0);

        // force_on and counter clear
        force_on = 1'b1;
        repeat (100) cyc();
        chk("force_en", en0, 1);
        force_on = 1'b0;
        repeat (8) cyc();
        chk("force_close", en0, 0);
        repeat (3) cyc();
        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        chk("clr_zero", cnt0, 0);
        cyc();
        chk("clr_inc", cnt0, 1);

        // reset in the middle of WAKE
        req = 1'b1;
        cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midwake_en0", en0, 0);
        chk("midwake_en1", en1, 0);
        chk("midwake_rdy1", rdy1, 0);
        compare_all();
        req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("postrst_en1", en1, 0);
        chk("postrst_rdy1", rdy1, 0);

        // randomized traffic; requester holds req until both units have transferred
        d0 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (req) begin
                if (m_xfer[0]) d0 = 1'b1;
                if (m_xfer[1]) d1 = 1'b1;
                if (d0 && d1) req = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                req = 1'b1; d0 = 1'b0; d1 = 1'b0;
            end
            if (busy) busy = ($urandom_range(0, 5) != 0);
            else      busy = ($urandom_range(0, 29) == 0);
            if (force_on) force_on = ($urandom_range(0, 49) != 0);
            else          force_on = ($urandom_range(0, 299) == 0);
            clr_count = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 compare_all();
                req = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
